// File: rtl/rv32e_cpu.sv
// -----------------------------------------------------------------------------
// rv32e_cpu -- single-cycle RV32E integer core.
//
// Every clock edge fetches, executes and retires one instruction. PC and the
// destination register update on the same rising edge. There is no pipeline,
// so there is no FSM, and stall/flush are tied low.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   imem_addr/imem_read  instruction fetch address (= PC) and request
//   imem_data            instruction word, combinational reply to imem_addr
//   dmem_addr            load/store byte address (rs1 + imm)
//   dmem_data_in         load word, combinational reply (word aligned)
//   dmem_data_out        store data, replicated into every candidate lane
//   dmem_read/write      load / store strobes
//   dmem_byte_enable     written byte lanes, bit n = bits [8n+7:8n]
//   debug_*              PC, register file (x16..x31 read as 0),
//                        current instruction, stall/flush (always 0)
//
// Memory handshake: there is no ready/valid back-pressure. A request is the
// strobe itself: imem_read is high whenever reset is released; dmem_read or
// dmem_write is high for exactly the cycle of a load/store. Memory must answer
// reads combinationally in that cycle and commit writes on the next rising
// edge. All strobes and byte enables are forced low while reset is asserted.
// -----------------------------------------------------------------------------
module rv32e_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        imem_read,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] debug_pc,
    output logic [31:0] debug_registers [0:31],
    output logic [31:0] debug_instruction,
    output logic        debug_stall,
    output logic        debug_flush
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // State: PC and x1..x15 (x0 is not stored at all).
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [1:15];
    logic [31:0] rf_d [1:15];

    // Instruction fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = imem_data;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Register read: indices 0 and 16..31 fall through to zero.
    logic [31:0] rs1_val, rs2_val;
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        for (int i = 1; i < 16; i++) begin
            if (rs1 == 5'(i)) rs1_val = rf_q[i];
            if (rs2 == 5'(i)) rs2_val = rf_q[i];
        end
    end

    // Execute
    logic [31:0] alu_b, alu_res, mem_addr, ld_shift, st_data;
    logic        alu_alt, alu_ok, br_taken;
    logic        wb_en, mem_rd, mem_wr;
    logic [31:0] wb_val;
    logic [3:0]  byte_en;
    logic [15:0] ld_half;

    always_comb begin
        // ALU operand and validity for OP-IMM / OP. funct7[5] selects SUB/SRA;
        // on OP-IMM only the shift-right encoding may carry it.
        alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
        alu_alt = 1'b0;
        alu_ok  = 1'b1;
        if (opcode == OP_REG) begin
            alu_alt = funct7[5];
            alu_ok  = (funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (funct3 == 3'b001) begin
            alu_ok  = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
            alu_alt = funct7[5];
            alu_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end

        case (funct3)
            3'b000:  alu_res = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                       : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase

        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase

        mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
        // Loads: shift the addressed byte down to lane 0; halfword by addr[1].
        ld_shift = dmem_data_in >> {mem_addr[1:0], 3'b000};
        ld_half  = mem_addr[1] ? dmem_data_in[31:16] : dmem_data_in[15:0];

        pc_d    = pc_q + 32'd4;
        wb_en   = 1'b0;
        wb_val  = '0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        byte_en = 4'b0000;
        st_data = '0;

        // Anything not matched below (FENCE, SYSTEM, bad funct3/funct7)
        // falls through as a NOP.
        case (opcode)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc_q + imm_u;
            end
            OP_JAL: begin
                wb_en  = 1'b1;
                wb_val = pc_q + 32'd4;
                pc_d   = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_en  = 1'b1;
                    wb_val = pc_q + 32'd4;
                    pc_d   = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000: begin wb_en = 1'b1; wb_val = {{24{ld_shift[7]}}, ld_shift[7:0]}; end
                    3'b001: begin wb_en = 1'b1; wb_val = {{16{ld_half[15]}}, ld_half}; end
                    3'b010: begin wb_en = 1'b1; wb_val = dmem_data_in; end
                    3'b100: begin wb_en = 1'b1; wb_val = {24'b0, ld_shift[7:0]}; end
                    3'b101: begin wb_en = 1'b1; wb_val = {16'b0, ld_half}; end
                    default: ;
                endcase
                mem_rd = wb_en;
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        mem_wr  = 1'b1;
                        byte_en = 4'b0001 << mem_addr[1:0];
                        st_data = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        mem_wr  = 1'b1;
                        byte_en = mem_addr[1] ? 4'b1100 : 4'b0011;
                        st_data = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        mem_wr  = 1'b1;
                        byte_en = 4'b1111;
                        st_data = rs2_val;
                    end
                    default: ;
                endcase
            end
            OP_IMM, OP_REG: begin
                if (alu_ok) begin
                    wb_en  = 1'b1;
                    wb_val = alu_res;
                end
            end
            default: ;
        endcase
    end

    // Register write-back: rd = 0 and rd >= 16 match no entry and are dropped.
    always_comb begin
        rf_d = rf_q;
        for (int i = 1; i < 16; i++) begin
            if (wb_en && rd == 5'(i)) rf_d[i] = wb_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int i = 1; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            rf_q <= rf_d;
        end
    end

    // Outputs; all request strobes are masked while reset is held low.
    assign imem_addr        = pc_q;
    assign imem_read        = reset;
    assign dmem_addr        = mem_addr;
    assign dmem_data_out    = st_data;
    assign dmem_read        = mem_rd & reset;
    assign dmem_write       = mem_wr & reset;
    assign dmem_byte_enable = reset ? byte_en : 4'b0000;

    assign debug_pc          = pc_q;
    assign debug_instruction = imem_data;
    assign debug_stall       = 1'b0;
    assign debug_flush       = 1'b0;

    always_comb begin
        for (int i = 0; i < 32; i++) debug_registers[i] = '0;
        for (int i = 1; i < 16; i++) debug_registers[i] = rf_q[i];
    end

endmodule

// File: tb/tb_rv32e_cpu.sv
// -----------------------------------------------------------------------------
// tb_rv32e_cpu -- directed programs with hand-computed PC traces, stores and
// final register values. The driver pushes expected PCs and stores into
// queues; a negedge monitor pops and compares whenever the core retires an
// instruction or asserts dmem_write.
// -----------------------------------------------------------------------------
module tb_rv32e_cpu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_data_in, dmem_data_out;
    logic        imem_read, dmem_read, dmem_write, debug_stall, debug_flush;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] debug_pc, debug_instruction;
    logic [31:0] dbg_regs [0:31];

    rv32e_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .imem_read         (imem_read),
        .dmem_addr         (dmem_addr),
        .dmem_data_in      (dmem_data_in),
        .dmem_data_out     (dmem_data_out),
        .dmem_read         (dmem_read),
        .dmem_write        (dmem_write),
        .dmem_byte_enable  (dmem_byte_enable),
        .debug_pc          (debug_pc),
        .debug_registers   (dbg_regs),
        .debug_instruction (debug_instruction),
        .debug_stall       (debug_stall),
        .debug_flush       (debug_flush)
    );

    // ---------------- memories ----------------
    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    assign imem_data    = imem[imem_addr[7:2]];
    assign dmem_data_in = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_write) begin
            for (int n = 0; n < 4; n++)
                if (dmem_byte_enable[n]) dmem[dmem_addr[7:2]][8*n +: 8] <= dmem_data_out[8*n +: 8];
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_pc_q[$];
    logic [67:0] exp_st_q[$];   // {addr, byte_enable, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: one retired instruction per negedge while reset is released.
    always @(negedge clk) begin
        logic [67:0] e;
        if (!reset) begin
            check("rst_imem_read",  {31'b0, imem_read},  32'd0);
            check("rst_dmem_read",  {31'b0, dmem_read},  32'd0);
            check("rst_dmem_write", {31'b0, dmem_write}, 32'd0);
            check("rst_byte_en",    {28'b0, dmem_byte_enable}, 32'd0);
        end else begin
            if (exp_pc_q.size() > 0) check("pc", debug_pc, exp_pc_q.pop_front());
            check("imem_read", {31'b0, imem_read}, 32'd1);
            check("stall_flush", {30'b0, debug_stall, debug_flush}, 32'd0);
            if (dmem_write) begin
                if (exp_st_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_store: addr %08h be %b data %08h at pc %08h",
                             dmem_addr, dmem_byte_enable, dmem_data_out, debug_pc);
                end else begin
                    e = exp_st_q.pop_front();
                    check("st_addr", dmem_addr, e[67:36]);
                    check("st_be",   {28'b0, dmem_byte_enable}, {28'b0, e[35:32]});
                    check("st_data", dmem_data_out, e[31:0]);
                end
            end else if (!dmem_read) begin
                check("idle_byte_en", {28'b0, dmem_byte_enable}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Hold reset over a rising edge, then blank both memories.
    task automatic hold_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 64; i++) begin
            imem[i] = NOP;
            dmem[i] = '0;
        end
    endtask

    // Release reset (just after a rising edge) and let n instructions retire.
    task automatic run(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_pcs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_pc_q.push_back(first + 32'(4 * i));
    endtask

    task automatic push_st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_st_q.push_back({a, be, d});
    endtask

    task automatic check_reg(input int idx, input logic [31:0] exp);
        check($sformatf("x%0d", idx), dbg_regs[idx], exp);
    endtask

    task automatic check_drained(input string prog);
        check({prog, "_pc_q_left"}, 32'(exp_pc_q.size()), 32'd0);
        check({prog, "_st_q_left"}, 32'(exp_st_q.size()), 32'd0);
        exp_pc_q.delete();
        exp_st_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        hold_reset();
        check("reset_pc", debug_pc, 32'h0);
        for (int i = 0; i < 32; i++) check_reg(i, 32'h0);

        // Branch / jump program
        imem[0] = 32'h00500093; imem[1] = 32'h00A00113; imem[2] = 32'h00208863;
        imem[3] = 32'h00100193; imem[4] = 32'h0100006F; imem[5] = 32'h00000013;
        imem[6] = 32'h00200213; imem[7] = 32'h0080006F; imem[8] = 32'h00300293;
        imem[9] = 32'h00000013;
        push_pcs(32'h00, 5);
        push_pcs(32'h20, 3);
        run(8);
        check_reg(1, 32'd5); check_reg(2, 32'd10); check_reg(3, 32'd1);
        check_reg(4, 32'd0); check_reg(5, 32'd3);
        check_drained("branch");

        // Word store, byte/half loads with sign and zero extension
        hold_reset();
        imem[0] = 32'hFFF00093;  // addi x1,x0,-1
        imem[1] = 32'h00102023;  // sw   x1,0(x0)
        imem[2] = 32'h00100103;  // lb   x2,1(x0)
        imem[3] = 32'h00204183;  // lbu  x3,2(x0)
        imem[4] = 32'h00201203;  // lh   x4,2(x0)
        imem[5] = 32'h00205283;  // lhu  x5,2(x0)
        push_pcs(32'h00, 7);
        push_st(32'h0, 4'b1111, 32'hFFFF_FFFF);
        run(7);
        check_reg(1, 32'hFFFF_FFFF); check_reg(2, 32'hFFFF_FFFF); check_reg(3, 32'h0000_00FF);
        check_reg(4, 32'hFFFF_FFFF); check_reg(5, 32'h0000_FFFF);
        check_drained("load");

        // Byte and halfword store lanes
        hold_reset();
        imem[0] = 32'h01200093;  // addi x1,x0,0x12
        imem[1] = 32'h001001A3;  // sb   x1,3(x0)
        imem[2] = 32'h00101123;  // sh   x1,2(x0)
        push_pcs(32'h00, 4);
        push_st(32'h3, 4'b1000, 32'h1212_1212);
        push_st(32'h2, 4'b1100, 32'h0012_0012);
        run(4);
        check("mem_word0", dmem[0], 32'h0012_0000);
        check_drained("store");

        // ALU, taken unsigned branch, LUI/AUIPC
        hold_reset();
        imem[0]  = 32'hFF800093;  // addi x1,x0,-8
        imem[1]  = 32'h00300113;  // addi x2,x0,3
        imem[2]  = 32'h402081B3;  // sub  x3,x1,x2
        imem[3]  = 32'h4020D233;  // sra  x4,x1,x2
        imem[4]  = 32'h0020D2B3;  // srl  x5,x1,x2
        imem[5]  = 32'h0020A333;  // slt  x6,x1,x2
        imem[6]  = 32'h0020B3B3;  // sltu x7,x1,x2
        imem[7]  = 32'h00116463;  // bltu x2,x1,+8
        imem[8]  = 32'h00100413;  // addi x8,x0,1 (skipped)
        imem[9]  = 32'h123454B7;  // lui  x9,0x12345
        imem[10] = 32'h00001517;  // auipc x10,1
        push_pcs(32'h00, 8);
        push_pcs(32'h24, 3);
        run(11);
        check_reg(1, 32'hFFFF_FFF8); check_reg(3, 32'hFFFF_FFF5); check_reg(4, 32'hFFFF_FFFF);
        check_reg(5, 32'h1FFF_FFFF); check_reg(6, 32'd1);         check_reg(7, 32'd0);
        check_reg(8, 32'd0);         check_reg(9, 32'h1234_5000); check_reg(10, 32'h0000_1028);
        check_drained("alu");

        // x0 and out-of-range registers
        hold_reset();
        imem[0] = 32'h00900093;  // addi x1,x0,9
        imem[1] = 32'h00500013;  // addi x0,x0,5
        imem[2] = 32'h00700813;  // addi x16,x0,7
        imem[3] = 32'h000800B3;  // add  x1,x16,x0
        push_pcs(32'h00, 5);
        run(5);
        check_reg(0, 32'd0); check_reg(16, 32'd0); check_reg(1, 32'd0);
        check_drained("x0");

        // JAL / JALR with odd target cleared to even
        hold_reset();
        imem[4] = 32'h008000EF;  // jal  x1,+8 at 0x10
        imem[6] = 32'h00308067;  // jalr x0,3(x1) at 0x18
        push_pcs(32'h00, 5);
        exp_pc_q.push_back(32'h18);
        exp_pc_q.push_back(32'h16);
        exp_pc_q.push_back(32'h1A);
        exp_pc_q.push_back(32'h16);
        run(9);
        check_reg(1, 32'h14);
        check_drained("jump");

        // Reset pulse while a store is about to execute
        hold_reset();
        imem[0] = 32'hFFF00093;  // addi x1,x0,-1
        imem[1] = 32'h00102023;  // sw   x1,0(x0)
        exp_pc_q.push_back(32'h0);
        reset = 1'b1;
        @(posedge clk); #2;      // addi retires, sw is now current
        reset = 1'b0;
        @(posedge clk); #2;
        check("midrst_pc", debug_pc, 32'h0);
        check_reg(1, 32'h0);
        check("midrst_mem", dmem[0], 32'h0);
        push_pcs(32'h00, 3);
        push_st(32'h0, 4'b1111, 32'hFFFF_FFFF);
        run(3);
        check_reg(1, 32'hFFFF_FFFF);
        check("midrst_mem_after", dmem[0], 32'hFFFF_FFFF);
        check_drained("midrst");

        reset = 1'b0;
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32e_cpu.md
RV32E_CPU -- requirements
Module: rv32e_cpu

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 imem_addr  output  32  byte address of current instruction (equals PC).
REQ-005 imem_data  input  32  instruction word, combinational response to imem_addr.
REQ-006 imem_read  output  1  fetch request, 1 whenever reset is deasserted.
REQ-007 dmem_addr  output  32  load/store byte address (rs1 + imm).
REQ-008 dmem_data_in  input  32  load word, combinational response to dmem_addr (word-aligned).
REQ-009 dmem_data_out  output  32  store data, lane-aligned.
REQ-010 dmem_read  output  1  high during a load.
REQ-011 dmem_write  output  1  high during a store; memory writes at the next rising edge.
REQ-012 dmem_byte_enable  output  4  byte lanes written; bit n = bits [8n+7:8n].
REQ-013 debug_pc  output  32  current PC.
REQ-014 debug_registers  output  array [0:31] of 32  architectural register values.
REQ-015 debug_instruction  output  32  instruction currently executing (imem_data).
REQ-016 debug_stall, debug_flush  output  1 each  constant 0.

Function
REQ-017 Single-cycle core: one instruction fetched, executed and retired per clock; PC and rd update on the same rising edge.
REQ-018 16 registers x0-x15 (RV32E); x0 reads 0, writes ignored.
REQ-019 rs1/rs2 index >= 16 reads 0; rd >= 16 write discarded; debug_registers[16..31] = 0.
REQ-020 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
REQ-021 All arithmetic 32-bit modulo 2^32; shifts use shamt[4:0]; SLT/BLT signed, SLTU/BLTU unsigned.
REQ-022 Immediates sign-extended per I/S/B/U/J formats.
REQ-023 Next PC: taken branch or JAL = PC + imm; JALR = (rs1 + imm) & ~1; otherwise PC + 4.
REQ-024 JAL/JALR write PC + 4 to rd.
REQ-025 Stores: SW enable 1111, data rs2; SH enable 0011 (addr[1]=0) or 1100, halfword replicated in both halves; SB enable 0001<<addr[1:0], byte replicated in all lanes.
REQ-026 Loads: byte/halfword selected by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 Misaligned accesses take no trap; lanes chosen per REQ-025/026 from low address bits.
REQ-028 FENCE, ECALL, EBREAK and any unsupported encoding execute as NOP (PC + 4, no register or memory write).
REQ-029 dmem_read, dmem_write and dmem_byte_enable are 0 for non-memory instructions.

Reset
REQ-030 reset=0 at a rising edge: PC <= RESET_PC, x1-x15 <= 0; no register write or memory write occurs that cycle.
REQ-031 While reset=0: imem_read=0, dmem_read=0, dmem_write=0, dmem_byte_enable=0.
REQ-032 Reset reasserted mid-program aborts the current instruction; execution restarts at RESET_PC on the first edge with reset=1.

Verification
REQ-033 Program 00500093, 00A00113, 00208863, 00100193, 0100006F, 00000013, 00200213, 0080006F, 00300293, 00000013 at 0x00 -> PC sequence 00,04,08,0C,10,20,24,28; final x1=5, x2=10, x3=1, x4=0, x5=3.
REQ-034 addi x1,x0,-1; sw x1,0(x0); lb x2,1(x0); lbu x3,2(x0) -> SW enable 1111 data FFFFFFFF; x2=FFFFFFFF, x3=000000FF.
REQ-035 addi x1,x0,0x12; sb x1,3(x0) -> enable 1000, dmem_data_out=12121212; sh x1,2(x0) -> enable 1100.
REQ-036 addi x0,x0,5; addi x16,x0,7; add x1,x16,x0 -> x0=0, debug_registers[16]=0, x1=0.
REQ-037 jal x1,+8 at 0x10 -> PC=0x18, x1=0x14; jalr x0,3(x1) with x1=0x14 -> PC=0x16.
REQ-038 Assert reset=0 for one edge mid-program -> PC=RESET_PC, x1-x15=0, no dmem_write asserted during that cycle.
